// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle CPU sequencer: fetch, decode, execute, data access, writeback and trap,
// sharing one memory port, with per-phase wait timeouts.
//
// state      | meaning
// IDLE       | waiting for run
// FETCH      | instruction request held until grant
// FETCH_WAIT | waiting for instruction data
// DECODE     | external decode valid, illegal check
// EXECUTE    | latch result/redirect, choose path
// MEM        | data request held until grant
// MEM_WAIT   | waiting for load data
// WRITEBACK  | single register-file write cycle
// TRAP       | fault reported until run drops
module cpu_seq_ctrl #(
  parameter int XLEN     = 32,
  parameter int AW       = 16,
  parameter int TIMEOUT  = 15,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic [3:0]       state,
  output logic [AW-1:0]    pc,
  output logic [XLEN-1:0]  ir,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_wb,
  input  logic             dec_illegal,
  input  logic [XLEN-1:0]  ex_result,
  input  logic [XLEN-1:0]  st_data,
  input  logic             ex_redirect,
  input  logic [AW-1:0]    ex_target,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             rf_we,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_FETCH = 4'd1, S_FETCH_WAIT = 4'd2, S_DECODE = 4'd3, S_EXECUTE = 4'd4,
    S_MEM = 4'd5, S_MEM_WAIT = 4'd6, S_WRITEBACK = 4'd7, S_TRAP = 4'd8
  } state_t;

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LOAD = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] PC_RST  = AW'(RESET_PC);

  state_t            state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d, addr_q, addr_d, tgt_q, tgt_d;
  logic [XLEN-1:0]   ir_q, ir_d, wdata_q, wdata_d, wb_q, wb_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic [1:0]        cause_q, cause_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic              we_q, we_d, redir_q, redir_d;
  logic              retire, to_hit;
  logic [XLEN-1:0]   unused_ex;

  // Only the low AW bits of ex_result form a data address.
  assign unused_ex = ex_result;

  // Down-counter reaches terminal count on the last permitted wait cycle.
  assign to_hit = (TIMEOUT != 0) && (wait_q == '0);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    cause_d   = cause_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    wb_d      = wb_q;
    redir_d   = redir_q;
    tgt_d     = tgt_q;
    wait_d    = wait_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rf_we     = 1'b0;
    rf_wdata  = '0;

    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_gnt) state_d = S_FETCH_WAIT;
        else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_FETCH_WAIT: begin
        if (mem_rvalid) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        if (dec_illegal || (dec_load && dec_store)) begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end else state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        redir_d = ex_redirect;
        tgt_d   = ex_target;
        if (dec_load || dec_store) begin
          state_d = S_MEM;
          addr_d  = ex_result[AW-1:0];
          wdata_d = st_data;
          we_d    = dec_store;
        end else if (dec_wb) begin
          state_d = S_WRITEBACK;
          wb_d    = ex_result;
        end else retire = 1'b1;
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_gnt) begin
          if (we_q) retire = 1'b1;
          else state_d = S_MEM_WAIT;
        end else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b11;
        end
      end
      S_MEM_WAIT: begin
        if (mem_rvalid) begin
          wb_d    = mem_rdata;
          state_d = S_WRITEBACK;
        end else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b11;
        end
      end
      S_WRITEBACK: begin
        rf_we    = 1'b1;
        rf_wdata = wb_q;
        retire   = 1'b1;
      end
      S_TRAP: begin
        if (!run) begin
          state_d = S_IDLE;
          cause_d = 2'b00;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // redir_d/tgt_d carry either the live EXECUTE inputs or the values latched there.
    if (retire) begin
      pc_d      = redir_d ? tgt_d : pc_q + AW'(4);
      instret_d = instret_q + CNT_W'(1);
      state_d   = run ? S_FETCH : S_IDLE;
    end

    if (state_d != state_q) wait_d = TO_LOAD;
    else if (wait_q != '0) wait_d = wait_q - TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_RST;
      ir_q      <= '0;
      instret_q <= '0;
      cause_q   <= '0;
      wait_q    <= TO_LOAD;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      wb_q      <= '0;
      redir_q   <= 1'b0;
      tgt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
      cause_q   <= cause_d;
      wait_q    <= wait_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      wb_q      <= wb_d;
      redir_q   <= redir_d;
      tgt_q     <= tgt_d;
    end
  end

  assign state      = state_q;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign instret    = instret_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: table vectors, directed corner sequences and a random
// instruction stream checked against a transaction-level model of fetches, data accesses and writes.
module tb_cpu_seq_ctrl;
  localparam int XLEN = 32;
  localparam int AW   = 16;
  localparam int CW   = 32;
  localparam int NV   = 10;
  localparam int NR   = 40;
  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_MEM_WAIT = 4'd6, ST_TRAP = 4'd8;
  localparam logic [XLEN-1:0] SK = 32'h5A5A_A5A5;

  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  logic [3:0] state;
  logic [AW-1:0] pc, ex_target, mem_addr;
  logic [XLEN-1:0] ir, ex_result, st_data, mem_wdata, mem_rdata, rf_wdata;
  logic dec_load, dec_store, dec_wb, dec_illegal, ex_redirect;
  logic mem_req, mem_we, mem_gnt, mem_rvalid, rf_we, trap;
  logic [1:0] trap_cause;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  // Bench-side decoder: bit0 wb, bit1 load, bit2 store, bit3 branch, bit4 illegal, [31:16] immediate.
  assign dec_wb      = ir[0];
  assign dec_load    = ir[1];
  assign dec_store   = ir[2];
  assign ex_redirect = ir[3];
  assign dec_illegal = ir[4];
  assign ex_result   = {ir[31:16], ir[31:16]};
  assign ex_target   = ir[31:16];
  assign st_data     = ir ^ SK;

  cpu_seq_ctrl #(.XLEN(XLEN), .AW(AW), .TIMEOUT(4), .RESET_PC(0), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .state(state), .pc(pc), .ir(ir),
    .dec_load(dec_load), .dec_store(dec_store), .dec_wb(dec_wb), .dec_illegal(dec_illegal),
    .ex_result(ex_result), .st_data(st_data), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_wdata(rf_wdata), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  typedef struct {
    logic [AW-1:0]   addr;
    logic            we;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;
    logic            fetch;
    int              glat;
    int              rlat;
  } acc_t;

  typedef struct {
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] ldata;
    int              dglat;
    logic [AW-1:0]   exp_pc;
    int              exp_ret;
    int              exp_rf;
    logic            exp_trap;
    logic [1:0]      exp_cause;
  } vec_t;

  acc_t acc_q[$];
  logic [XLEN-1:0] rf_q[$];
  vec_t vecs[NV];
  int total = 0, bad = 0;
  int fetch_cnt = 0, rf_cnt = 0, n_rf = 0;
  logic [3:0] st_seq[6];
  logic       we_seq[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: observed 0x%0h at %0t", name, act, $time);
  endtask

  // Transaction-level model: one instruction becomes its expected accesses, writes and next pc.
  task automatic model_push(input logic [XLEN-1:0] word, input logic [XLEN-1:0] ldata,
                            input int fg, input int fr, input int dg, input int dr,
                            inout logic [AW-1:0] mpc);
    logic [AW-1:0] imm;
    imm = word[31:16];
    acc_q.push_back('{mpc, 1'b0, '0, word, 1'b1, fg, fr});
    if (word[4] || (word[1] && word[2])) return;
    if (word[1]) begin
      acc_q.push_back('{imm, 1'b0, '0, ldata, 1'b0, dg, dr});
      rf_q.push_back(ldata);
      n_rf++;
    end else if (word[2]) begin
      acc_q.push_back('{imm, 1'b1, word ^ SK, '0, 1'b0, dg, dr});
    end else if (word[0]) begin
      rf_q.push_back({imm, imm});
      n_rf++;
    end
    mpc = word[3] ? imm : mpc + 16'd4;
  endtask

  // Memory responder and register-file monitor.
  initial begin
    int gnt_cnt, rd_cnt, rd_lat;
    logic rd_pending;
    logic [XLEN-1:0] rd_data;
    acc_t cur;
    gnt_cnt = 0; rd_cnt = 0; rd_lat = 0; rd_pending = 1'b0; rd_data = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (!rst_n) begin
        rd_pending = 1'b0;
        gnt_cnt    = 0;
        fetch_cnt  = 0;
        rf_cnt     = 0;
        acc_q.delete();
        rf_q.delete();
      end else begin
        if (rf_we) begin
          rf_cnt++;
          if (rf_q.size() == 0) fail_now("rf_unexpected", rf_wdata);
          else check("rf_wdata", rf_wdata, rf_q.pop_front());
        end
        if (rd_pending) begin
          if (rd_cnt >= rd_lat) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd_data;
            rd_pending = 1'b0;
          end else rd_cnt++;
        end
        if (mem_req) begin
          if (acc_q.size() == 0) fail_now("mem_unexpected", mem_addr);
          else begin
            cur = acc_q[0];
            check("mem_addr", mem_addr, cur.addr);
            check("mem_we", mem_we, cur.we);
            if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
            if (gnt_cnt >= cur.glat) begin
              mem_gnt = 1'b1;
              gnt_cnt = 0;
              void'(acc_q.pop_front());
              if (cur.fetch) fetch_cnt++;
              if (!cur.we) begin
                rd_pending = 1'b1;
                rd_cnt     = 0;
                rd_lat     = cur.rlat;
                rd_data    = cur.rdata;
              end
            end else gnt_cnt++;
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    repeat (2) @(negedge clk);
    n_rf  = 0;
    rst_n = 1'b1;
  endtask

  task automatic wait_fetch(input int n, input int budget);
    int b = 0;
    while (fetch_cnt < n && b < budget) begin
      @(negedge clk);
      b++;
    end
    if (fetch_cnt < n) fail_now("fetch_wait_expired", fetch_cnt);
  endtask

  task automatic wait_state(input logic [3:0] st, input int budget, input string name);
    int b = 0;
    while (state !== st && b < budget) begin
      @(negedge clk);
      b++;
    end
    if (state !== st) fail_now(name, state);
  endtask

  initial begin
    logic [AW-1:0] pcm;
    logic [XLEN-1:0] word;
    logic [4:0] lo;
    int kind;

    vecs[0] = '{32'h1234_0001, 32'h0,         0,  16'h0004, 1, 1, 1'b0, 2'b00};
    vecs[1] = '{32'h7777_0000, 32'h0,         0,  16'h0004, 1, 0, 1'b0, 2'b00};
    vecs[2] = '{32'h0040_0002, 32'hDEAD_BEEF, 3,  16'h0004, 1, 1, 1'b0, 2'b00};
    vecs[3] = '{32'h0080_0004, 32'h0,         1,  16'h0004, 1, 0, 1'b0, 2'b00};
    vecs[4] = '{32'h0100_0008, 32'h0,         0,  16'h0100, 1, 0, 1'b0, 2'b00};
    vecs[5] = '{32'h0200_0009, 32'h0,         0,  16'h0200, 1, 1, 1'b0, 2'b00};
    vecs[6] = '{32'h0000_0011, 32'h0,         0,  16'h0000, 0, 0, 1'b1, 2'b01};
    vecs[7] = '{32'h0040_0006, 32'h0,         0,  16'h0000, 0, 0, 1'b1, 2'b01};
    vecs[8] = '{32'h0060_0002, 32'h1111_2222, 99, 16'h0000, 0, 0, 1'b1, 2'b11};
    vecs[9] = '{32'h0084_0005, 32'h0,         2,  16'h0004, 1, 0, 1'b0, 2'b00};
    st_seq = '{ST_FETCH, 4'd2, 4'd3, 4'd4, 4'd7, ST_FETCH};
    we_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset values and quiet idle.
    repeat (3) @(negedge clk);
    check("rst_state", state, ST_IDLE);
    check("rst_pc", pc, 16'h0000);
    check("rst_ir", ir, 32'h0);
    check("rst_instret", instret, 32'h0);
    check("rst_trap", trap, 1'b0);
    check("rst_cause", trap_cause, 2'b00);
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 16'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_rfwe", rf_we, 1'b0);
    check("rst_rfwdata", rf_wdata, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_state", state, ST_IDLE);
    check("idle_req", mem_req, 1'b0);

    // Cycle-exact ALU instruction with immediate grant and next-cycle data.
    do_reset();
    pcm = '0;
    model_push(32'hABCD_0001, 32'h0, 0, 0, 0, 0, pcm);
    model_push(32'h0, 32'h0, 100000, 0, 0, 0, pcm);
    run = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("seq_state", state, st_seq[c]);
      check("seq_rfwe", rf_we, we_seq[c]);
      if (c == 0) check("seq_fetch_addr", mem_addr, 16'h0000);
      if (c == 2) check("seq_ir", ir, 32'hABCD_0001);
    end
    check("seq_pc", pc, 16'h0004);
    check("seq_instret", instret, 32'd1);

    // Single-instruction table; run drops after the fetch is granted.
    for (int v = 0; v < NV; v++) begin
      do_reset();
      pcm = '0;
      model_push(vecs[v].word, vecs[v].ldata, 0, 0, vecs[v].dglat, 1, pcm);
      run = 1'b1;
      wait_fetch(1, 20);
      run = 1'b0;
      wait_state(vecs[v].exp_trap ? ST_TRAP : ST_IDLE, 40, "vec_end_state");
      check("vec_trap", trap, vecs[v].exp_trap);
      check("vec_cause", trap_cause, vecs[v].exp_cause);
      check("vec_pc", pc, vecs[v].exp_pc);
      check("vec_instret", instret, vecs[v].exp_ret);
      check("vec_rf_count", rf_cnt, vecs[v].exp_rf);
      if (vecs[v].exp_trap) check("vec_trap_req", mem_req, 1'b0);
    end

    // Branch to the top of the address space, then wrap on the following instruction.
    do_reset();
    pcm = '0;
    model_push(32'hFFFC_0008, 32'h0, 0, 0, 0, 0, pcm);
    model_push(32'h00AA_0001, 32'h0, 1, 1, 0, 0, pcm);
    run = 1'b1;
    wait_fetch(2, 40);
    run = 1'b0;
    wait_state(ST_IDLE, 40, "wrap_idle");
    check("wrap_pc", pc, 16'h0000);
    check("wrap_instret", instret, 32'd2);

    // Fetch never granted: exactly four waiting cycles, then trap; run low clears it.
    do_reset();
    pcm = '0;
    model_push(32'h0, 32'h0, 100000, 0, 0, 0, pcm);
    run = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("fto_fetch", state, ST_FETCH);
    end
    @(negedge clk);
    check("fto_state", state, ST_TRAP);
    check("fto_trap", trap, 1'b1);
    check("fto_cause", trap_cause, 2'b10);
    check("fto_req", mem_req, 1'b0);
    check("fto_pc", pc, 16'h0000);
    run = 1'b0;
    @(negedge clk);
    check("fto_idle", state, ST_IDLE);
    check("fto_trap_clr", trap, 1'b0);
    check("fto_cause_clr", trap_cause, 2'b00);

    // Asynchronous reset while waiting for load data.
    do_reset();
    pcm = '0;
    model_push(32'h1111_0001, 32'h0, 0, 0, 0, 0, pcm);
    model_push(32'h0050_0002, 32'h0, 0, 0, 0, 100000, pcm);
    run = 1'b1;
    wait_state(ST_MEM_WAIT, 60, "mw_reach");
    check("mw_instret_pre", instret, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mw_rst_state", state, ST_IDLE);
    check("mw_rst_req", mem_req, 1'b0);
    check("mw_rst_pc", pc, 16'h0000);
    check("mw_rst_instret", instret, 32'd0);
    check("mw_rst_ir", ir, 32'h0);

    // Random instruction stream with random grant/data latencies.
    do_reset();
    pcm = '0;
    for (int i = 0; i < NR; i++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: lo = 5'h01;
        1: lo = 5'h00;
        2: lo = 5'h02 | 5'($urandom_range(0, 1));
        3: lo = 5'h04 | 5'($urandom_range(0, 1));
        4: lo = 5'h08;
        default: lo = 5'h09;
      endcase
      word = {16'($urandom), 11'($urandom), lo};
      model_push(word, $urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                 $urandom_range(0, 3), $urandom_range(0, 2), pcm);
    end
    run = 1'b1;
    wait_fetch(NR, 2000);
    run = 1'b0;
    wait_state(ST_IDLE, 60, "rand_idle");
    check("rand_pc", pc, pcm);
    check("rand_instret", instret, NR);
    check("rand_rf_count", rf_cnt, n_rf);
    check("rand_rf_left", rf_q.size(), 0);
    check("rand_acc_left", acc_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpu_seq_ctrl.md
CPU_SEQ_CTRL -- requirements
Module: cpu_seq_ctrl

Interface
REQ-001 Parameter XLEN, 32, data/instruction width (>=16).
REQ-002 Parameter AW, 16, address width; PC and memory addresses wrap modulo 2^AW.
REQ-003 Parameter TIMEOUT, 15, max wait cycles per memory phase; 0 disables timeout.
REQ-004 Parameter RESET_PC, 0, PC value after reset.
REQ-005 Parameter CNT_W, 32, retired-instruction counter width.
REQ-006 Single clock clk; reset rst_n asynchronous, active-low.
REQ-007 Ports (name dir width meaning):
clk in 1 clock; rst_n in 1 async active-low reset;
run in 1 execute enable; state out 4 current FSM state;
pc out AW current PC; ir out XLEN latched instruction;
dec_load, dec_store, dec_wb, dec_illegal in 1 each, external decode of ir, valid in DECODE/EXECUTE;
ex_result in XLEN ALU result or load/store address; st_data in XLEN store data;
ex_redirect in 1, ex_target in AW, branch taken/target, sampled in EXECUTE;
mem_req out 1, mem_we out 1, mem_addr out AW, mem_wdata out XLEN, mem_gnt in 1, mem_rvalid in 1, mem_rdata in XLEN, shared memory port;
rf_we out 1, rf_wdata out XLEN register-file write;
trap out 1, trap_cause out 2 (01 illegal, 10 fetch timeout, 11 data timeout);
instret out CNT_W retired count.

Function
REQ-008 States/encoding: IDLE 0, FETCH 1, FETCH_WAIT 2, DECODE 3, EXECUTE 4, MEM 5, MEM_WAIT 6, WRITEBACK 7, TRAP 8; all other codes -> IDLE next cycle.
REQ-009 IDLE: run=1 -> FETCH; else stay.
REQ-010 FETCH: mem_req=1, mem_we=0, mem_addr=pc, held stable until mem_gnt=1 -> FETCH_WAIT.
REQ-011 FETCH_WAIT: mem_rvalid=1 -> ir<=mem_rdata, DECODE; mem_rvalid outside FETCH_WAIT/MEM_WAIT ignored.
REQ-012 DECODE (1 cycle): dec_illegal=1 -> TRAP, cause 01; else -> EXECUTE.
REQ-013 EXECUTE (1 cycle): latch ex_redirect/ex_target; dec_load or dec_store -> MEM with address ex_result[AW-1:0], data st_data latched; else dec_wb -> WRITEBACK with ex_result latched; else retire.
REQ-014 dec_load and dec_store both 1 -> treated as illegal, TRAP cause 01.
REQ-015 MEM: mem_req=1, mem_we=dec_store, address/data stable until mem_gnt; store + gnt -> retire; load + gnt -> MEM_WAIT.
REQ-016 MEM_WAIT: mem_rvalid=1 -> latch mem_rdata, WRITEBACK.
REQ-017 WRITEBACK: rf_we=1 for exactly one cycle with rf_wdata = latched value; then retire.
REQ-018 Retire: pc <= latched redirect ? ex_target : pc+4 (mod 2^AW); instret+1 (wraps at 2^CNT_W); next FETCH if run=1 else IDLE.
REQ-019 run deasserted mid-instruction: current instruction completes and retires, then IDLE.
REQ-020 Timeout: wait counter clears on entering FETCH/FETCH_WAIT/MEM/MEM_WAIT, increments each cycle without the awaited gnt/rvalid; reaching TIMEOUT -> TRAP, cause 10 (fetch phases) or 11 (data phases); mem_req drops on TRAP entry.
REQ-021 TRAP: trap=1, trap_cause held, no memory or RF activity, pc/instret frozen; run=0 -> IDLE, trap and trap_cause clear.
REQ-022 mem_req, rf_we zero in all states not listed as driving them.

Reset
REQ-023 rst_n=0 immediately forces state=IDLE, pc=RESET_PC, ir=0, instret=0, trap=0, trap_cause=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rf_we=0, rf_wdata=0, regardless of state.
REQ-024 After reset release, no activity until run=1 sampled high.

Verification
REQ-025 Reset, run=1, ALU instr dec_wb=1, gnt in request cycle, rvalid next cycle -> fetch addr 0x0000, rf_we pulse 5th cycle, pc=0x0004, instret=1, next FETCH 6th cycle.
REQ-026 Load, ex_result=0x0040, mem_gnt delayed 3 cycles -> mem_req/mem_addr=0x0040/mem_we=0 stable 4 cycles, rf_wdata=mem_rdata, one rf_we pulse.
REQ-027 Branch ex_redirect=1, ex_target=0x0100 -> next fetch 0x0100; non-branch at pc=0xFFFC (AW=16) -> next pc 0x0000.
REQ-028 TIMEOUT=4, mem_gnt never in FETCH -> TRAP after 4 wait cycles, trap_cause=10, mem_req=0; run=0 -> IDLE, trap=0.
REQ-029 dec_illegal=1 -> TRAP cause 01, no rf_we, no data mem_req, instret unchanged.
REQ-030 rst_n low during MEM_WAIT -> same-cycle mem_req=0, state=IDLE, pc=RESET_PC, instret=0.
